dht11_responder: RTL and testbench

Emulates the sensor end of the DHT11 single-wire protocol on an FPGA pin.
- Detects the host start pulse.
- Sends the 80 µs low / 80 µs high acknowledge.
- Sends 40 data bits (humidity int, humidity dec, temperature int, temperature dec, checksum) using standard DHT11 bit timing.

Used as a loopback target for the DHT11 bus master, and as a sensor stand-in on boards without a physical DHT11.

---
 rtl/dht11_pkg.sv | 37 +++
 rtl/dht11_responder_if.sv | 32 +++
 rtl/dht11_us_tick.sv | 29 ++
 rtl/dht11_responder.sv | 217 +++++++++++++++++++++
 tb/tb_dht11_responder.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: FSM state encoding, default protocol timing (in µs)
// and the frame checksum rule.
package dht11_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HOST_LOW = 3'd1,
    S_DLY      = 3'd2,
    S_ACK_LO   = 3'd3,
    S_ACK_HI   = 3'd4,
    S_BIT_LO   = 3'd5,
    S_BIT_HI   = 3'd6,
    S_END_LO   = 3'd7
  } dht11_state_e;

  localparam int CLK_DIV_50MHZ = 50;
  localparam int T_18MS        = 18000;
  localparam int T_WAIT        = 30;
  localparam int T_ACK         = 80;
  localparam int T_BIT_LOW     = 50;
  localparam int T_ZERO        = 26;
  localparam int T_ONE         = 70;
  localparam int FRAME_BITS    = 40;

  // Checksum is the plain 8-bit wrapping sum of the four data bytes.
  function automatic logic [7:0] dht11_csum(input logic [7:0] hum_int,
                                            input logic [7:0] hum_dec,
                                            input logic [7:0] tmp_int,
                                            input logic [7:0] tmp_dec);
    logic [7:0] sum;
    sum = hum_int + hum_dec;
    sum = sum + tmp_int;
    sum = sum + tmp_dec;
    return sum;
  endfunction

endpackage

// File: rtl/dht11_responder_if.sv
// Control/status bundle of the DHT11 responder. The master side owns the frame
// data and enable; the slave (responder) side reports status and its FSM state.
interface dht11_responder_if;
  import dht11_pkg::*;

  logic         enable;
  logic [7:0]   hum_int;
  logic [7:0]   hum_dec;
  logic [7:0]   tmp_int;
  logic [7:0]   tmp_dec;
  logic         csum_corrupt;

  // busy is a level; frame_done, start_short and collision are single-cycle
  // pulses, mutually exclusive, with no handshake (the consumer must sample
  // every cycle). Data inputs are captured only at start acceptance.
  logic         busy;
  logic         frame_done;
  logic         start_short;
  logic         collision;
  dht11_state_e state;

  modport master (
    output enable, hum_int, hum_dec, tmp_int, tmp_dec, csum_corrupt,
    input  busy, frame_done, start_short, collision, state
  );

  modport slave (
    input  enable, hum_int, hum_dec, tmp_int, tmp_dec, csum_corrupt,
    output busy, frame_done, start_short, collision, state
  );

endinterface

// File: rtl/dht11_us_tick.sv
// Microsecond tick divider: counts 0..CLK_DIV-1 and flags the terminal count.
// i_restart realigns the divider so a new state starts on a whole microsecond.
module dht11_us_tick #(
  parameter int CLK_DIV = 50
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] TERM = W'(CLK_DIV - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || i_restart) begin
      r_cnt <= '0;
    end else if (r_cnt == TERM) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == TERM);

endmodule

// File: rtl/dht11_responder.sv
// Sensor side of the DHT11 single-wire protocol: detects the host start pulse,
// answers with the acknowledge and shifts out a 40-bit frame on an open-drain pin.
module dht11_responder #(
  parameter int CLK_DIV     = dht11_pkg::CLK_DIV_50MHZ,
  parameter int T_START_MIN = dht11_pkg::T_18MS,
  parameter int T_WAIT      = dht11_pkg::T_WAIT,
  parameter int T_ACK       = dht11_pkg::T_ACK,
  parameter int T_BIT_LOW   = dht11_pkg::T_BIT_LOW,
  parameter int T_ZERO      = dht11_pkg::T_ZERO,
  parameter int T_ONE       = dht11_pkg::T_ONE
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  dht11_responder_if.slave io_if,
  inout  wire              dht11
);
  import dht11_pkg::dht11_state_e;
  import dht11_pkg::S_IDLE;
  import dht11_pkg::S_HOST_LOW;
  import dht11_pkg::S_DLY;
  import dht11_pkg::S_ACK_LO;
  import dht11_pkg::S_ACK_HI;
  import dht11_pkg::S_BIT_LO;
  import dht11_pkg::S_BIT_HI;
  import dht11_pkg::S_END_LO;
  import dht11_pkg::FRAME_BITS;
  import dht11_pkg::dht11_csum;

  localparam int CW = 16;
  localparam logic [CW-1:0] CNT_MAX     = '1;
  localparam logic [CW-1:0] C_START_MIN = CW'(T_START_MIN);
  localparam logic [CW-1:0] C_WAIT      = CW'(T_WAIT - 1);
  localparam logic [CW-1:0] C_ACK       = CW'(T_ACK - 1);
  localparam logic [CW-1:0] C_BIT_LOW   = CW'(T_BIT_LOW - 1);
  localparam logic [CW-1:0] C_ZERO      = CW'(T_ZERO - 1);
  localparam logic [CW-1:0] C_ONE       = CW'(T_ONE - 1);
  localparam logic [CW-1:0] C_COLL_SKIP = CW'(2);
  localparam logic [5:0]    LAST_BIT    = 6'(FRAME_BITS - 1);

  dht11_state_e  r_state;
  dht11_state_e  w_next_state;

  logic          r_sync_meta;
  logic          r_sync;
  logic [CW-1:0] r_us_cnt;
  logic [1:0]    r_low_ticks;
  logic [39:0]   r_frame;
  logic [5:0]    r_bit_idx;
  logic          r_busy;
  logic          r_frame_done;
  logic          r_start_short;
  logic          r_collision;
  logic          r_drive_low;
  logic          r_armed;

  logic          w_tick;
  logic          w_restart;
  logic          w_drive_low_nxt;
  logic          w_accept;
  logic          w_short;
  logic          w_done;
  logic          w_abort;
  logic          w_bit_step;
  logic          w_end_wait;
  logic          w_end_ack;
  logic          w_end_bit_low;
  logic          w_end_bit_hi;
  logic          w_long_enough;
  logic          w_coll_window;
  logic          w_collide;
  logic [7:0]    w_csum;

  dht11_us_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // Sync flops reset to 1 so an idle (pulled-up) bus is not mistaken for a start.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync_meta <= 1'b1;
      r_sync      <= 1'b1;
    end else begin
      r_sync_meta <= dht11;
      r_sync      <= r_sync_meta;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || w_restart) begin
      r_us_cnt <= '0;
    end else if (w_tick && (r_us_cnt != CNT_MAX)) begin
      r_us_cnt <= r_us_cnt + 1'b1;
    end
  end

  // A phase of N µs ends on the Nth tick after entry.
  assign w_end_wait    = w_tick && (r_us_cnt == C_WAIT);
  assign w_end_ack     = w_tick && (r_us_cnt == C_ACK);
  assign w_end_bit_low = w_tick && (r_us_cnt == C_BIT_LOW);
  assign w_end_bit_hi  = w_tick && (r_us_cnt == (r_frame[39] ? C_ONE : C_ZERO));
  assign w_long_enough = (r_us_cnt >= C_START_MIN);
  assign w_csum = dht11_csum(io_if.hum_int, io_if.hum_dec, io_if.tmp_int, io_if.tmp_dec)
                  ^ {8{io_if.csum_corrupt}};

  // The first 2 µs of a released phase are skipped: our own low is still
  // draining through the synchroniser.
  assign w_coll_window = ((r_state == S_ACK_HI) || (r_state == S_BIT_HI)) &&
                         (r_us_cnt >= C_COLL_SKIP);
  assign w_collide = w_coll_window && !r_sync && w_tick && (r_low_ticks == 2'd2);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || w_restart || !w_coll_window || r_sync) begin
      r_low_ticks <= 2'd0;
    end else if (w_tick && (r_low_ticks != 2'd3)) begin
      r_low_ticks <= r_low_ticks + 2'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (io_if.enable && r_armed && !r_sync) w_next_state = S_HOST_LOW;
      end
      S_HOST_LOW: begin
        if (r_sync) w_next_state = w_long_enough ? S_DLY : S_IDLE;
      end
      S_DLY: begin
        if (w_end_wait) w_next_state = S_ACK_LO;
      end
      S_ACK_LO: begin
        if (w_end_ack) w_next_state = S_ACK_HI;
      end
      S_ACK_HI: begin
        if (w_collide)      w_next_state = S_IDLE;
        else if (w_end_ack) w_next_state = S_BIT_LO;
      end
      S_BIT_LO: begin
        if (w_end_bit_low) w_next_state = S_BIT_HI;
      end
      S_BIT_HI: begin
        if (w_collide)         w_next_state = S_IDLE;
        else if (w_end_bit_hi) w_next_state = (r_bit_idx == LAST_BIT) ? S_END_LO : S_BIT_LO;
      end
      S_END_LO: begin
        if (w_end_bit_low) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_restart       = (w_next_state != r_state);
    w_drive_low_nxt = (w_next_state == S_ACK_LO) || (w_next_state == S_BIT_LO) ||
                      (w_next_state == S_END_LO);
    w_accept        = (r_state == S_HOST_LOW) && r_sync && w_long_enough;
    w_short         = (r_state == S_HOST_LOW) && r_sync && !w_long_enough;
    w_done          = (r_state == S_END_LO) && w_end_bit_low;
    w_abort         = ((r_state == S_ACK_HI) || (r_state == S_BIT_HI)) && w_collide;
    w_bit_step      = (r_state == S_BIT_HI) && w_end_bit_hi && !w_collide;
  end

  // The frame is re-armed only after the bus is seen high in IDLE, so the tail
  // of our own end-of-frame low or a colliding driver cannot look like a start.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_drive_low   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_start_short <= 1'b0;
      r_collision   <= 1'b0;
      r_busy        <= 1'b0;
      r_armed       <= 1'b0;
      r_frame       <= '0;
      r_bit_idx     <= '0;
    end else begin
      r_drive_low   <= w_drive_low_nxt;
      r_frame_done  <= w_done;
      r_start_short <= w_short;
      r_collision   <= w_abort;
      if (w_done || w_abort) begin
        r_armed <= 1'b0;
      end else if ((r_state == S_IDLE) && r_sync) begin
        r_armed <= 1'b1;
      end
      if (w_accept) begin
        r_frame   <= {io_if.hum_int, io_if.hum_dec, io_if.tmp_int, io_if.tmp_dec, w_csum};
        r_bit_idx <= '0;
        r_busy    <= 1'b1;
      end else if (w_bit_step) begin
        r_frame   <= {r_frame[38:0], 1'b0};
        r_bit_idx <= r_bit_idx + 6'd1;
      end
      if (w_done || w_abort) r_busy <= 1'b0;
    end
  end

  assign dht11             = r_drive_low ? 1'b0 : 1'bz;
  assign io_if.busy        = r_busy;
  assign io_if.frame_done  = r_frame_done;
  assign io_if.start_short = r_start_short;
  assign io_if.collision   = r_collision;
  assign io_if.state       = r_state;

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: a host model drives start pulses on the pulled-up
// bus, a bus monitor decodes the returned waveform and scores it against a queue.
module tb_dht11_responder;
  import dht11_pkg::*;

  localparam int CLK_DIV     = 4;
  localparam int T_START_MIN = 200;
  localparam int US          = CLK_DIV;
  localparam int ACK_US      = 80;
  localparam int LOW_US      = 50;
  localparam int ZERO_US     = 26;
  localparam int ONE_US      = 70;
  localparam int SEGS        = 84;

  localparam logic [1:0] K_FRAME = 2'd0;
  localparam logic [1:0] K_SHORT = 2'd1;
  localparam logic [1:0] K_COLL  = 2'd2;
  localparam logic [1:0] K_RST   = 2'd3;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic host_low = 1'b0;
  wire  dht11;

  assign dht11 = host_low ? 1'b0 : 1'bz;
  pullup (dht11);

  dht11_responder_if io_if ();

  dht11_responder #(
    .CLK_DIV     (CLK_DIV),
    .T_START_MIN (T_START_MIN)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .io_if   (io_if.slave),
    .dht11   (dht11)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int          tests = 0;
  int          fails = 0;
  logic [41:0] exp_q[$];
  int          seg_len[$];
  logic        seg_lvl[$];
  bit          capturing = 0;
  logic        prev_lvl = 1'b1;
  int          run_len = 0;
  int          dut_low_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d cycles, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic pop_expect(input logic [1:0] kind, output logic [39:0] data);
    logic [41:0] e;
    data = '0;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d, expected queue empty", kind);
    end else begin
      e = exp_q.pop_front();
      data = e[39:0];
      check("event_kind", 64'(kind), 64'(e[41:40]));
    end
  endtask

  // Decodes the captured segments: [0] delay high (partial), [1] ack low,
  // [2] ack high, then low/high pairs per bit, then the end-of-frame low.
  task automatic analyze_frame();
    logic [39:0] exp_data;
    logic [39:0] got;
    int          bad;
    int          lo;
    int          hi;
    logic        b;
    pop_expect(K_FRAME, exp_data);
    check("seg_count", 64'(seg_len.size()), 64'(SEGS));
    if (seg_len.size() == SEGS) begin
      check_range("ack_low", seg_len[1], (ACK_US - 1) * US, (ACK_US + 1) * US);
      check_range("ack_high", seg_len[2], (ACK_US - 1) * US, (ACK_US + 1) * US);
      bad = 0;
      got = '0;
      for (int i = 0; i < 40; i++) begin
        lo = seg_len[3 + 2 * i];
        hi = seg_len[4 + 2 * i];
        b  = (hi > 48 * US);
        if (lo < (LOW_US - 1) * US || lo > (LOW_US + 1) * US) bad++;
        if (b && (hi < (ONE_US - 1) * US || hi > (ONE_US + 1) * US)) bad++;
        if (!b && (hi < (ZERO_US - 1) * US || hi > (ZERO_US + 1) * US)) bad++;
        got = {got[38:0], b};
      end
      check("bit_timing_violations", 64'(bad), 64'd0);
      check_range("end_low", seg_len[83], (LOW_US - 1) * US, (LOW_US + 1) * US);
      check("frame_data", 64'(got), 64'(exp_data));
    end
    check("busy_after_done", 64'(io_if.busy), 64'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge sys_clk) begin
    logic [39:0] dummy;
    if (dht11 === 1'b0 && !host_low) dut_low_cycles++;
    if (sys_rst) begin
      if (capturing) pop_expect(K_RST, dummy);
      capturing = 0;
    end else begin
      if (capturing) begin
        if (dht11 === prev_lvl) begin
          run_len++;
        end else begin
          seg_len.push_back(run_len);
          seg_lvl.push_back(prev_lvl);
          prev_lvl = dht11;
          run_len = 1;
        end
      end else if (io_if.busy) begin
        capturing = 1;
        seg_len.delete();
        seg_lvl.delete();
        prev_lvl = dht11;
        run_len = 1;
      end
      if (io_if.start_short) begin
        pop_expect(K_SHORT, dummy);
        check("short_busy", 64'(io_if.busy), 64'd0);
      end
      if (io_if.collision) begin
        pop_expect(K_COLL, dummy);
        check("coll_busy", 64'(io_if.busy), 64'd0);
        check("coll_state", 64'(io_if.state), 64'(S_IDLE));
        capturing = 0;
      end
      if (io_if.frame_done) begin
        analyze_frame();
        capturing = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic host_pulse(input int us);
    @(posedge sys_clk);
    #1 host_low = 1'b1;
    repeat (us * US) @(posedge sys_clk);
    #1 host_low = 1'b0;
  endtask

  task automatic set_data(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] d, input logic corrupt);
    @(posedge sys_clk);
    #1;
    io_if.hum_int      = a;
    io_if.hum_dec      = b;
    io_if.tmp_int      = c;
    io_if.tmp_dec      = d;
    io_if.csum_corrupt = corrupt;
  endtask

  // Reference frame: four bytes, then their 8-bit sum, inverted on request.
  task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d, input logic corrupt);
    logic [7:0] cs;
    cs = a + b + c + d;
    if (corrupt) cs = ~cs;
    exp_q.push_back({K_FRAME, a, b, c, d, cs});
  endtask

  task automatic push_event(input logic [1:0] kind);
    exp_q.push_back({kind, 40'd0});
  endtask

  task automatic wait_segs(input int n, input string name);
    int k;
    k = 0;
    while (!(capturing && seg_len.size() >= n) && k < 20000) begin
      @(negedge sys_clk);
      k++;
    end
    tests++;
    if (k >= 20000) begin
      fails++;
      $display("FAIL %s: timeout after %0d cycles, expected %0d segments", name, k, n);
    end
  endtask

  task automatic wait_quiet(input int max_cycles, input string name);
    int k;
    k = 0;
    while ((io_if.busy || capturing || exp_q.size() != 0) && k < max_cycles) begin
      @(negedge sys_clk);
      k++;
    end
    tests++;
    if (k >= max_cycles) begin
      fails++;
      $display("FAIL %s: timeout with %0d expected items pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (20 * US) @(posedge sys_clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lows0;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [7:0]  rc;
    logic [7:0]  rd;
    logic        rcor;

    io_if.enable       = 1'b1;
    io_if.hum_int      = 8'h00;
    io_if.hum_dec      = 8'h00;
    io_if.tmp_int      = 8'h00;
    io_if.tmp_dec      = 8'h00;
    io_if.csum_corrupt = 1'b0;

    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_busy", 64'(io_if.busy), 64'd0);
    check("rst_frame_done", 64'(io_if.frame_done), 64'd0);
    check("rst_start_short", 64'(io_if.start_short), 64'd0);
    check("rst_collision", 64'(io_if.collision), 64'd0);
    check("rst_state", 64'(io_if.state), 64'(S_IDLE));
    check("rst_bus", 64'(dht11), 64'd1);
    sys_rst = 1'b0;
    repeat (10) @(posedge sys_clk);

    // Nominal frame; hum_int changes during bit 3 and must not leak into it.
    set_data(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
    push_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
    host_pulse(250);
    wait_segs(10, "bit3_reached");
    @(posedge sys_clk);
    #1 io_if.hum_int = 8'h40;
    wait_quiet(30000, "nominal_frame");

    // Too-short host low: start_short only, the responder never drives.
    lows0 = dut_low_cycles;
    push_event(K_SHORT);
    host_pulse(150);
    wait_quiet(2000, "short_start");
    check("short_no_drive", 64'(dut_low_cycles), 64'(lows0));

    // Collision 40 µs into the acknowledge high phase.
    set_data(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    push_event(K_COLL);
    host_pulse(205);
    wait_segs(2, "ack_high_reached");
    repeat (40 * US) @(posedge sys_clk);
    host_pulse(10);
    wait_quiet(4000, "collision");

    // All-ones data with an inverted checksum (0xFC sent as 0x03).
    set_data(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    host_pulse(205);
    wait_quiet(30000, "ones_corrupt_frame");

    // Reset in the low preamble of bit 20: bus must be released at once.
    set_data(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    push_event(K_RST);
    host_pulse(205);
    wait_segs(43, "bit20_reached");
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    check("midrst_bus", 64'(dht11), 64'd1);
    check("midrst_busy", 64'(io_if.busy), 64'd0);
    check("midrst_frame_done", 64'(io_if.frame_done), 64'd0);
    check("midrst_collision", 64'(io_if.collision), 64'd0);
    check("midrst_state", 64'(io_if.state), 64'(S_IDLE));
    sys_rst = 1'b0;
    wait_quiet(2000, "mid_reset");

    // Disabled: a valid-length start must be ignored entirely.
    io_if.enable = 1'b0;
    lows0 = dut_low_cycles;
    host_pulse(250);
    repeat (50 * US) @(posedge sys_clk);
    check("disabled_no_drive", 64'(dut_low_cycles), 64'(lows0));
    check("disabled_busy", 64'(io_if.busy), 64'd0);
    check("disabled_state", 64'(io_if.state), 64'(S_IDLE));
    check("disabled_no_event", 64'(exp_q.size()), 64'd0);

    // Re-enabled, random data and random checksum corruption.
    io_if.enable = 1'b1;
    ra   = 8'($urandom_range(0, 255));
    rb   = 8'($urandom_range(0, 255));
    rc   = 8'($urandom_range(0, 255));
    rd   = 8'($urandom_range(0, 255));
    rcor = 1'($urandom_range(0, 1));
    set_data(ra, rb, rc, rd, rcor);
    push_frame(ra, rb, rc, rd, rcor);
    host_pulse(T_START_MIN + $urandom_range(5, 60));
    wait_quiet(30000, "random_frame");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
